// File: rtl/prod_accumulator_if.sv
// prod_accumulator_if: control/product inputs and result-write outputs of prod_accumulator (err only with PROTO_CHECK_EN)
interface prod_accumulator_if #(parameter int W = 32);
  logic         mulOn;
  logic         outLoop;
  logic         mulEnd;
  logic [2*W-1:0] karatProd;
  logic         resWe;
  logic [2:0]   resAddr;
  logic [W-1:0] resData;
  logic         done;
`ifdef PROTO_CHECK_EN
  logic         err;
`endif
  modport master(
    output mulOn, outLoop, mulEnd, karatProd,
    input  resWe, resAddr, resData, done
`ifdef PROTO_CHECK_EN
    , err
`endif
  );
  modport slave(
    input  mulOn, outLoop, mulEnd, karatProd,
    output resWe, resAddr, resData, done
`ifdef PROTO_CHECK_EN
    , err
`endif
  );
endinterface

// File: rtl/prod_accumulator.sv
// prod_accumulator: product-scanning column accumulator retiring W-bit result words; PROTO_CHECK_EN adds sticky err
module prod_accumulator #(parameter int W = 32) (
  input  logic clk,
  input  logic rst,
  prod_accumulator_if.slave bus
);
  typedef enum logic {ACC, DONE} state_t;
  state_t state;
  logic [2*W+1:0] acc, sum;
  logic [2:0] wcnt;
  always_comb sum = acc + (bus.mulOn ? {2'b00, bus.karatProd} : '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc <= '0;
      wcnt <= '0;
      bus.resWe <= 1'b0;
      bus.resAddr <= '0;
      bus.resData <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.resWe <= 1'b0;
      if (state == ACC) begin
        if (bus.mulEnd) begin
          bus.resData <= sum[W-1:0];
          bus.resAddr <= wcnt;
          bus.resWe <= 1'b1;
          bus.done <= 1'b1;
          acc <= sum;
          state <= DONE;
        end else if (bus.outLoop && wcnt != 3'd7) begin
          bus.resData <= sum[W-1:0];
          bus.resAddr <= wcnt;
          bus.resWe <= 1'b1;
          acc <= sum >> W;
          wcnt <= wcnt + 3'd1;
        end else begin
          acc <= sum;
        end
      end
    end
  end
`ifdef PROTO_CHECK_EN
  logic viol;
  always_comb viol = (state == DONE) ? (bus.mulOn | bus.outLoop | bus.mulEnd)
                   : ((bus.mulOn & bus.outLoop) | (bus.outLoop & (wcnt == 3'd7))
                   | (bus.mulEnd & ((wcnt != 3'd7) | (acc[2*W+1:W] != '0))));
  always_ff @(posedge clk) bus.err <= rst ? 1'b0 : (bus.err | viol);
`endif
endmodule

// File: doc/prod_accumulator.md
# prod_accumulator

- Product-scanning accumulator and result writer that sits directly downstream of the 4×4-chunk multiplication control FSM and its Karatsuba sub-multiplier.
- Per chunk product, it consumes the sub-multiplier's 2W-bit product under `mulOn`.
- It accumulates column sums and, on each `outLoop`, retires one W-bit result word to the result memory.
- On `mulEnd` it writes the final carry word and raises `done`, producing the full 8W-bit product of two 4W-bit operands.

## Interface
Parameters:
- `W`, 32: chunk width. Operands are 4W bits; product is 8W bits.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `mulOn` in 1: add `karatProd` into the accumulator this cycle.
- `outLoop` in 1: retire the low word of the accumulator this cycle.
- `mulEnd` in 1: retire the final word and finish.
- `karatProd` in 2W: current chunk product from the sub-multiplier. Valid whenever `mulOn`=1.
- `resWe` out 1: result memory write enable.
- `resAddr` out 3: result word index, 0 = least significant.
- `resData` out W: result word.
- `done` out 1: product complete. Sticky until `rst`.
- `err` out 1: protocol error, sticky. Present only with `PROTO_CHECK_EN`.

## Operation
- Accumulator `acc` is 2W+2 bits wide.
  - Worst case is 4 products plus the carry-in from the previous column, which is below 2^(2W+2).
  - All additions are unsigned, zero-extended to 2W+2 bits, no truncation.
- Word counter `wcnt` is 3 bits and counts retired words.
- States:
  - **ACC**, entered on reset:
    - `mulOn`: `acc <= acc + karatProd`.
    - `outLoop`, only if `wcnt` < 7: `resData <= acc[W-1:0]`, `resAddr <= wcnt`, `resWe <= 1`, `acc <= acc >> W`, `wcnt <= wcnt + 1`.
    - `mulEnd`: `resData <= acc[W-1:0]`, `resAddr <= wcnt`, `resWe <= 1`, then go to DONE.
  - **DONE**: `done` = 1. All of `mulOn`, `outLoop` and `mulEnd` are ignored, with no writes. Leave only via `rst`.
- Simultaneous events:
  - `mulOn` & `outLoop`: the emitted word is `(acc + karatProd)[W-1:0]`, and `acc <= (acc + karatProd) >> W`.
  - `mulEnd` together with `mulOn` or `outLoop`: `mulEnd` wins. The sum is included if `mulOn` is asserted. `outLoop` is ignored.
- Boundary conditions:
  - `outLoop` when `wcnt` = 7: no write, `acc` unchanged.
  - `mulEnd` before 7 `outLoop`s: writes at the current `wcnt`, then DONE.
- Reset mid-operation: on the next edge, `acc`, `wcnt`, `resWe`, `resAddr`, `resData` and `done` all return to 0 and the state returns to ACC. A partial product is discarded.
- Normal sequence from the FSM:
  - Column i has min(i+1, 7−i) `mulOn` pulses, each followed by a single `outLoop`, for i = 0..6.
  - Then one `mulEnd` writes word 7.

## Timing
- Reset values: `resWe` = 0, `resAddr` = 0, `resData` = 0, `done` = 0, `err` = 0, `acc` = 0, `wcnt` = 0.
- `mulOn` sampled at edge N: the sum is visible to an `outLoop` at edge N+1 or later.
- `outLoop` or `mulEnd` sampled at edge N: `resWe`, `resAddr` and `resData` are registered and valid in cycle N+1.
  - `resWe` is a 1-cycle pulse.
  - `resAddr` and `resData` hold until the next write.
- `done` rises in the same cycle as the word-7 `resWe` pulse (cycle N+1 after `mulEnd`).
- Throughput: one control event per cycle. Back-to-back `outLoop`s are legal.

## Configuration
- `PROTO_CHECK_EN` defined: the `err` port exists and is set (sticky until `rst`), one cycle after any of:
  - `mulOn` & `outLoop` asserted together;
  - `outLoop` with `wcnt` = 7;
  - `mulEnd` with `wcnt` ≠ 7;
  - `mulEnd` with `acc[2W+1:W]` ≠ 0;
  - any of `mulOn`, `outLoop`, `mulEnd` asserted while in DONE.
  - Functional behaviour is unchanged.
- `PROTO_CHECK_EN` undefined: no `err` port and no checker logic.

## Test plan
- **All-ones operands** (W=32, A = B = 2^128−1), full FSM sequence with exact chunk products.
  - Words 0..7 = 0x00000001, 0, 0, 0, 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFF.
  - `done` = 1, `err` = 0.
- **Single product**: A = 3, B = 5, full sequence.
  - Word 0 = 15, all other words 0.
  - Exactly 8 `resWe` pulses, with `resAddr` 0..7 in order.
- **Column carry**: column 3 gets four products of 0xFFFFFFFE00000001 each.
  - Word 3 = 0x00000004.
  - Carry 0x3FFFFFFF8 (0x3_FFFFFFF8) propagates, so word 4 includes 0xFFFFFFF8 plus the column-4 sum.
- **Mid-op reset**: `rst` asserted after the 3rd `outLoop`.
  - Next cycle: all outputs 0.
  - A fresh A = B = 1 run yields word 0 = 1, other words 0.
- **Post-done and overflow events**:
  - `mulOn` and `outLoop` after `done`: no `resWe`, `done` stays 1.
  - 8th `outLoop`: no write.
  - With `PROTO_CHECK_EN`, `err` = 1 one cycle later.
- **Simultaneous `mulOn` & `outLoop`**: `acc` = 7 and `karatProd` = 0x1_00000002 (0x100000002).
  - Emitted word = 9, next `acc` = 1.
  - `err` = 1 with `PROTO_CHECK_EN`.
